mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Memory-access (MEM) stage of the pipeline: consumes the EX-stage outputs (ALU result as address, store data, func3, opcode), drives a word-wide data-memory request/acknowledge interface, and delivers aligned, sign/zero-extended load data or pass-through ALU results to write-back. It runs a small request FSM and stalls upstream while a memory transaction is outstanding.

## Interface
Parameters: none. Opcode constants `LD` and `S` come from parameters.vh; func3 encodings are RV32I (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010).
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset; one clock, no other reset
- i_valid  in  1  EX outputs valid this cycle
- i_opcode  in  7  instruction opcode
- i_func3  in  3  access width / signedness
- i_result  in  32  ALU result (byte address for LD/S)
- i_data_store  in  32  store data (rs2)
- i_rd  in  5  destination register
- i_reg_we  in  1  instruction writes rd
- o_stall  out  1  upstream must hold EX outputs
- o_mem_req  out  1  memory request, held until ack
- o_mem_we  out  1  1 = write
- o_mem_addr  out  32  word-aligned address {i_result[31:2],2'b00}
- o_mem_wdata  out  32  lane-replicated store data
- o_mem_wstrb  out  4  byte enables (0000 for reads)
- i_mem_ack  in  1  memory completed the request
- i_mem_rdata  in  32  read data, valid with i_mem_ack
- o_wb_valid  out  1  one-cycle retirement pulse
- o_wb_we  out  1  write rd
- o_wb_rd  out  5  destination register
- o_wb_data  out  32  write-back data
- o_exc  out  1  one-cycle pulse: misaligned or illegal func3 access

## Operation
- FSM states IDLE, WAIT. Reset -> IDLE.
- IDLE, i_valid, opcode not LD/S: capture at edge; next cycle o_wb_valid=1, o_wb_data=i_result, o_wb_rd=i_rd, o_wb_we=i_reg_we. Stays IDLE; no stall.
- IDLE, i_valid, LD/S, aligned, legal func3: at edge register address/wdata/wstrb/we, go WAIT, o_mem_req=1. o_stall is combinationally 1 in this cycle and throughout WAIT.
- WAIT: o_mem_req and all o_mem_* held stable. Edge with i_mem_ack=1 -> IDLE, o_mem_req=0, o_wb_valid pulse next cycle. i_valid/inputs ignored in WAIT.
- Alignment: halfword requires addr[0]=0; word requires addr[1:0]=00. Illegal func3 (LD: 011,110,111; S: >010) counts as faulting. Faulting access: no memory request, o_exc and o_wb_valid pulse one cycle after accept with o_wb_we=0; no stall.
- Store: SB wdata={4{d[7:0]}}, wstrb=0001<<addr[1:0]; SH wdata={2{d[15:0]}}, wstrb=0011<<addr[1:0]; SW wdata=d, wstrb=1111. Store retirement: o_wb_we=0.
- Load: select lane with registered addr[1:0]: LB/LBU byte at rdata[8*a+:8], sign/zero-extend; LH/LHU half at rdata[16*a[1]+:16], sign/zero-extend; LW full word. o_wb_we = registered i_reg_we.
- i_mem_ack in IDLE is ignored.

## Timing
- Reset (async assert, sync release effect): state IDLE; all outputs 0 (o_stall, o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_wstrb, o_wb_*, o_exc). Reset in WAIT abandons the transaction; a later ack is ignored.
- Non-memory latency: 1 cycle, throughput 1/cycle.
- Memory latency: accept edge E0, o_mem_req high after E0, ack sampled at E1 earliest -> o_wb_valid high E1..E2. Minimum 2 cycles; each extra ack-wait cycle adds one.
- o_wb_valid, o_exc: exactly one cycle per retired instruction; low otherwise.
- o_stall falls in the cycle after the ack edge; back-to-back memory ops: next accept at the edge following ack.

## Test plan
- Reset: assert rst_n=0 mid-WAIT -> all outputs 0 immediately, state IDLE; ack 2 cycles later yields no o_wb_valid.
- R pass-through: i_result=32'h4444_1555, rd=5, we=1 -> next cycle o_wb_valid=1, o_wb_data=32'h4444_1555, o_wb_rd=5, o_mem_req=0.
- SB addr 32'h0000_0103, data 32'hABCD_EFAB -> o_mem_addr=32'h0000_0100, wdata=32'hABAB_ABAB, wstrb=1000, we=1; ack after 3 wait cycles -> o_stall high 4 cycles, o_wb_valid with o_wb_we=0.
- LB addr 32'h0000_0008+2, rdata 32'h12F4_5678 -> o_wb_data=32'hFFFF_FFF4; LBU same -> 32'h0000_00F4; LHU addr ..0A -> 32'h0000_12F4.
- LW addr 32'h0000_0006 -> no o_mem_req, o_exc=1 and o_wb_valid=1 (o_wb_we=0) next cycle, o_stall=0.
- Back-to-back SW then LW with ack=1 immediately -> each completes in 2 cycles; LW o_wb_data equals i_mem_rdata.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM pipeline stage. Issues word-wide data-memory requests for
// loads/stores, aligns and extends load data, and retires every instruction to write-back.
module mem_access_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_valid,
  input  logic [6:0]  i_opcode,
  input  logic [2:0]  i_func3,
  input  logic [31:0] i_result,
  input  logic [31:0] i_data_store,
  input  logic [4:0]  i_rd,
  input  logic        i_reg_we,
  output logic        o_stall,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_wstrb,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata,
  output logic        o_wb_valid,
  output logic        o_wb_we,
  output logic [4:0]  o_wb_rd,
  output logic [31:0] o_wb_data,
  output logic        o_exc
);
  // Opcode values mirror LD / S from parameters.vh (RV32I LOAD / STORE)
  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] S  = 7'b0100011;

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;
  state_t state_q, state_d;

  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_wstrb_q, mem_wstrb_d;
  logic [1:0]  off_q, off_d;
  logic [2:0]  func3_q, func3_d;
  logic [4:0]  rd_q, rd_d;
  logic        reg_we_q, reg_we_d;
  logic        wb_valid_q, wb_valid_d;
  logic        wb_we_q, wb_we_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        exc_q, exc_d;

  logic        is_ld, is_st, is_mem, f3_ok, aligned, take_mem;
  logic [31:0] st_wdata, ld_data;
  logic [3:0]  st_wstrb;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    is_ld  = (i_opcode == LD);
    is_st  = (i_opcode == S);
    is_mem = is_ld | is_st;
    f3_ok  = 1'b0;
    if (is_ld)      f3_ok = (i_func3[1:0] != 2'b11) && (i_func3 != 3'b110);
    else if (is_st) f3_ok = (i_func3 <= 3'b010);
    case (i_func3[1:0])
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~i_result[0];
      2'b10:   aligned = (i_result[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
    take_mem = i_valid & is_mem & f3_ok & aligned;
    case (i_func3[1:0])
      2'b00: begin
        st_wdata = {4{i_data_store[7:0]}};
        st_wstrb = 4'b0001 << i_result[1:0];
      end
      2'b01: begin
        st_wdata = {2{i_data_store[15:0]}};
        st_wstrb = 4'b0011 << i_result[1:0];
      end
      default: begin
        st_wdata = i_data_store;
        st_wstrb = 4'b1111;
      end
    endcase
  end

  // Lane select uses the offset captured at accept, not the live EX address
  always_comb begin
    ld_byte = i_mem_rdata[{off_q, 3'b000} +: 8];
    ld_half = i_mem_rdata[{off_q[1], 4'b0000} +: 16];
    case (func3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = i_mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (take_mem) state_d = WAIT;
      WAIT:    if (i_mem_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    off_d       = off_q;
    func3_d     = func3_q;
    rd_d        = rd_q;
    reg_we_d    = reg_we_q;
    wb_valid_d  = 1'b0;
    wb_we_d     = 1'b0;
    wb_rd_d     = wb_rd_q;
    wb_data_d   = wb_data_q;
    exc_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (take_mem) begin
          mem_we_d    = is_st;
          mem_addr_d  = {i_result[31:2], 2'b00};
          mem_wdata_d = is_st ? st_wdata : 32'd0;
          mem_wstrb_d = is_st ? st_wstrb : 4'b0000;
          off_d       = i_result[1:0];
          func3_d     = i_func3;
          rd_d        = i_rd;
          reg_we_d    = i_reg_we;
        end else if (i_valid) begin
          wb_valid_d = 1'b1;
          wb_rd_d    = i_rd;
          if (is_mem) begin
            exc_d     = 1'b1;
            wb_data_d = 32'd0;
          end else begin
            wb_we_d   = i_reg_we;
            wb_data_d = i_result;
          end
        end
      end
      WAIT: begin
        if (i_mem_ack) begin
          wb_valid_d  = 1'b1;
          wb_rd_d     = rd_q;
          wb_we_d     = ~mem_we_q & reg_we_q;
          wb_data_d   = mem_we_q ? 32'd0 : ld_data;
          mem_we_d    = 1'b0;
          mem_addr_d  = 32'd0;
          mem_wdata_d = 32'd0;
          mem_wstrb_d = 4'b0000;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      mem_wstrb_q <= 4'b0000;
      off_q       <= 2'b00;
      func3_q     <= 3'b000;
      rd_q        <= 5'd0;
      reg_we_q    <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_we_q     <= 1'b0;
      wb_rd_q     <= 5'd0;
      wb_data_q   <= 32'd0;
      exc_q       <= 1'b0;
    end else begin
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      off_q       <= off_d;
      func3_q     <= func3_d;
      rd_q        <= rd_d;
      reg_we_q    <= reg_we_d;
      wb_valid_q  <= wb_valid_d;
      wb_we_q     <= wb_we_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
      exc_q       <= exc_d;
    end
  end

  // Stall is forced low while reset is held so every output reads 0 in reset
  assign o_stall     = rst_n & ((state_q == WAIT) | ((state_q == IDLE) & take_mem));
  assign o_mem_req   = (state_q == WAIT);
  assign o_mem_we    = mem_we_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_mem_wstrb = mem_wstrb_q;
  assign o_wb_valid  = wb_valid_q;
  assign o_wb_we     = wb_we_q;
  assign o_wb_rd     = wb_rd_q;
  assign o_wb_data   = wb_data_q;
  assign o_exc       = exc_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed and randomized checks of mem_access_unit against a
// behavioural model of address alignment, lane replication and load extension.
module tb_mem_access_unit;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_S  = 7'b0100011;
  localparam logic [6:0] OP_R  = 7'b0110011;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid, i_reg_we, i_mem_ack;
  logic [6:0]  i_opcode;
  logic [2:0]  i_func3;
  logic [31:0] i_result, i_data_store, i_mem_rdata;
  logic [4:0]  i_rd;
  logic        o_stall, o_mem_req, o_mem_we, o_wb_valid, o_wb_we, o_exc;
  logic [31:0] o_mem_addr, o_mem_wdata, o_wb_data;
  logic [3:0]  o_mem_wstrb;
  logic [4:0]  o_wb_rd;

  int n_checks = 0;
  int n_pass   = 0;

  logic        r_req, r_we, r_wbv, r_wbwe, r_exc, r_stall_after, r_after;
  logic [31:0] r_addr, r_wdata, r_wbdata;
  logic [3:0]  r_wstrb;
  logic [4:0]  r_wbrd;
  int          r_stall, r_unstable, r_spur;

  typedef struct packed {
    logic        mem;
    logic        exc;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] wb_data;
    logic        wb_we;
  } exp_t;

  mem_access_unit dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_opcode(i_opcode), .i_func3(i_func3),
    .i_result(i_result), .i_data_store(i_data_store), .i_rd(i_rd), .i_reg_we(i_reg_we),
    .o_stall(o_stall), .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_wstrb(o_mem_wstrb), .i_mem_ack(i_mem_ack),
    .i_mem_rdata(i_mem_rdata), .o_wb_valid(o_wb_valid), .o_wb_we(o_wb_we), .o_wb_rd(o_wb_rd),
    .o_wb_data(o_wb_data), .o_exc(o_exc)
  );

  always #5 clk = ~clk;

  // Reference: access size from func3, fault if illegal or not a multiple of size
  function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] d, input logic rwe, input logic [31:0] rdata);
    exp_t e;
    int size, off;
    logic [31:0] mask, val;
    e = '0;
    off = int'(a[1:0]);
    if (op != OP_LD && op != OP_S) begin
      e.wb_data = a;
      e.wb_we   = rwe;
      return e;
    end
    size = 0;
    if (f3 == 3'd0 || (op == OP_LD && f3 == 3'd4)) size = 1;
    else if (f3 == 3'd1 || (op == OP_LD && f3 == 3'd5)) size = 2;
    else if (f3 == 3'd2) size = 4;
    if (size == 0 || (off % size) != 0) begin
      e.exc = 1'b1;
      return e;
    end
    e.mem  = 1'b1;
    e.addr = a & 32'hFFFF_FFFC;
    if (op == OP_S) begin
      e.we    = 1'b1;
      e.wstrb = 4'(((1 << size) - 1) << off);
      if (size == 1)      e.wdata = {24'd0, d[7:0]} * 32'h0101_0101;
      else if (size == 2) e.wdata = {16'd0, d[15:0]} * 32'h0001_0001;
      else                e.wdata = d;
    end else begin
      mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
      val  = (rdata >> (8 * off)) & mask;
      if (f3[2] == 1'b0 && size < 4 && val[8 * size - 1]) val = val | ~mask;
      e.wb_data = val;
      e.wb_we   = rwe;
    end
    return e;
  endfunction

  // Drives one instruction from IDLE to retirement and records what the DUT did
  task automatic run_op(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, input logic [4:0] rd, input logic rwe,
                        input logic [31:0] rdata, input int ack_wait);
    r_stall = 0; r_unstable = 0; r_spur = 0;
    r_req = 1'b0; r_we = 1'b0; r_addr = '0; r_wdata = '0; r_wstrb = '0;
    i_valid = 1'b1; i_opcode = op; i_func3 = f3; i_result = a; i_data_store = d;
    i_rd = rd; i_reg_we = rwe;
    #1 r_stall += int'(o_stall);
    @(posedge clk); #1;
    if (o_mem_req) begin
      r_req = 1'b1; r_we = o_mem_we; r_addr = o_mem_addr; r_wdata = o_mem_wdata; r_wstrb = o_mem_wstrb;
      for (int k = 0; k <= ack_wait; k++) begin
        r_stall += int'(o_stall);
        if ({o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_wstrb} !==
            {1'b1, r_we, r_addr, r_wdata, r_wstrb}) r_unstable++;
        if (o_wb_valid || o_exc) r_spur++;
        i_result = $urandom; i_data_store = $urandom; i_rd = 5'($urandom);
        i_mem_ack   = (k == ack_wait);
        i_mem_rdata = (k == ack_wait) ? rdata : $urandom;
        @(posedge clk); #1;
      end
    end
    i_valid = 1'b0; i_mem_ack = 1'b0;
    #1;
    r_wbv = o_wb_valid; r_wbwe = o_wb_we; r_wbrd = o_wb_rd; r_wbdata = o_wb_data;
    r_exc = o_exc; r_stall_after = o_stall;
    @(posedge clk); #1;
    r_after = o_wb_valid | o_exc;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; i_valid = 1'b0; i_opcode = '0; i_func3 = '0; i_result = '0;
    i_data_store = '0; i_rd = '0; i_reg_we = 1'b0; i_mem_ack = 1'b0; i_mem_rdata = '0;
    #1;
    n_checks++; if ({o_stall, o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_wstrb, o_wb_valid,
                     o_wb_we, o_wb_rd, o_wb_data, o_exc} !== '0)
      $display("FAIL reset_outputs got nonzero outputs stall=%b req=%b wbv=%b", o_stall, o_mem_req, o_wb_valid);
    else n_pass++;
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b1; i_opcode = OP_S; i_func3 = 3'b010; i_result = 32'h40; i_data_store = 32'h1234_5678;
    i_rd = 5'd3; i_reg_we = 1'b0;
    @(posedge clk); #1 i_valid = 1'b0;
    n_checks++; if (o_mem_req !== 1'b1) $display("FAIL reset_enter_wait got=%b exp=1", o_mem_req); else n_pass++;
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    n_checks++; if ({o_stall, o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_wstrb, o_wb_valid,
                     o_wb_we, o_wb_rd, o_wb_data, o_exc} !== '0)
      $display("FAIL reset_mid_wait got req=%b stall=%b addr=%h exp all zero", o_mem_req, o_stall, o_mem_addr);
    else n_pass++;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1 i_mem_ack = 1'b1; i_mem_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1 i_mem_ack = 1'b0;
    n_checks++; if ({o_wb_valid, o_mem_req, o_stall} !== 3'b000)
      $display("FAIL reset_late_ack got wbv/req/stall=%b exp=000", {o_wb_valid, o_mem_req, o_stall}); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (o_wb_valid !== 1'b0) $display("FAIL reset_late_ack2 got=%b exp=0", o_wb_valid); else n_pass++;
  endtask

  task automatic test_passthrough();
    run_op(OP_R, 3'b000, 32'h4444_1555, 32'h0, 5'd5, 1'b1, 32'h0, 0);
    n_checks++; if (r_wbv !== 1'b1) $display("FAIL pass_wbv got=%b exp=1", r_wbv); else n_pass++;
    n_checks++; if (r_wbdata !== 32'h4444_1555) $display("FAIL pass_data got=%h exp=44441555", r_wbdata); else n_pass++;
    n_checks++; if (r_wbrd !== 5'd5) $display("FAIL pass_rd got=%0d exp=5", r_wbrd); else n_pass++;
    n_checks++; if (r_wbwe !== 1'b1) $display("FAIL pass_we got=%b exp=1", r_wbwe); else n_pass++;
    n_checks++; if ({r_req, r_stall != 0, r_exc, r_after} !== 4'b0000)
      $display("FAIL pass_side got req/stall/exc/after=%b exp=0000", {r_req, r_stall != 0, r_exc, r_after}); else n_pass++;
    i_valid = 1'b1; i_opcode = OP_R; i_reg_we = 1'b1;
    for (int i = 0; i < 3; i++) begin
      i_result = 32'h1000_0000 + 32'(i); i_rd = 5'(i + 1);
      #1;
      n_checks++; if (o_stall !== 1'b0) $display("FAIL pass_stream_stall got=%b exp=0", o_stall); else n_pass++;
      @(posedge clk); #1;
      n_checks++; if ({o_wb_valid, o_wb_data, o_wb_rd} !== {1'b1, 32'h1000_0000 + 32'(i), 5'(i + 1)})
        $display("FAIL pass_stream got v=%b data=%h rd=%0d exp data=%h", o_wb_valid, o_wb_data, o_wb_rd, 32'h1000_0000 + 32'(i));
      else n_pass++;
    end
    i_valid = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (o_wb_valid !== 1'b0) $display("FAIL pass_stream_end got=%b exp=0", o_wb_valid); else n_pass++;
  endtask

  task automatic test_store();
    run_op(OP_S, 3'b000, 32'h0000_0103, 32'hABCD_EFAB, 5'd9, 1'b1, 32'h0, 2);
    n_checks++; if (r_addr !== 32'h0000_0100) $display("FAIL sb_addr got=%h exp=00000100", r_addr); else n_pass++;
    n_checks++; if (r_wdata !== 32'hABAB_ABAB) $display("FAIL sb_wdata got=%h exp=ababab ab", r_wdata); else n_pass++;
    n_checks++; if (r_wstrb !== 4'b1000) $display("FAIL sb_wstrb got=%b exp=1000", r_wstrb); else n_pass++;
    n_checks++; if (r_we !== 1'b1) $display("FAIL sb_we got=%b exp=1", r_we); else n_pass++;
    n_checks++; if (r_stall != 4) $display("FAIL sb_stall_cycles got=%0d exp=4", r_stall); else n_pass++;
    n_checks++; if (r_unstable != 0) $display("FAIL sb_hold got=%0d unstable cycles exp=0", r_unstable); else n_pass++;
    n_checks++; if ({r_wbv, r_wbwe, r_exc} !== 3'b100) $display("FAIL sb_retire got v/we/exc=%b exp=100", {r_wbv, r_wbwe, r_exc}); else n_pass++;
    n_checks++; if ({r_stall_after, r_after, r_spur != 0} !== 3'b000)
      $display("FAIL sb_after got stall/again/spur=%b exp=000", {r_stall_after, r_after, r_spur != 0}); else n_pass++;
  endtask

  task automatic test_load();
    run_op(OP_LD, 3'b000, 32'h0000_000A, 32'h0, 5'd4, 1'b1, 32'h12F4_5678, 1);
    n_checks++; if (r_wbdata !== 32'hFFFF_FFF4) $display("FAIL lb_data got=%h exp=fffffff4", r_wbdata); else n_pass++;
    n_checks++; if ({r_req, r_we, r_wstrb, r_addr} !== {1'b1, 1'b0, 4'b0000, 32'h0000_0008})
      $display("FAIL lb_req got req=%b we=%b strb=%b addr=%h", r_req, r_we, r_wstrb, r_addr); else n_pass++;
    n_checks++; if ({r_wbv, r_wbwe, r_wbrd} !== {1'b1, 1'b1, 5'd4}) $display("FAIL lb_wb got v=%b we=%b rd=%0d", r_wbv, r_wbwe, r_wbrd); else n_pass++;
    run_op(OP_LD, 3'b100, 32'h0000_000A, 32'h0, 5'd6, 1'b1, 32'h12F4_5678, 0);
    n_checks++; if (r_wbdata !== 32'h0000_00F4) $display("FAIL lbu_data got=%h exp=000000f4", r_wbdata); else n_pass++;
    run_op(OP_LD, 3'b101, 32'h0000_000A, 32'h0, 5'd8, 1'b1, 32'h12F4_5678, 0);
    n_checks++; if (r_wbdata !== 32'h0000_12F4) $display("FAIL lhu_data got=%h exp=000012f4", r_wbdata); else n_pass++;
    n_checks++; if (r_stall != 2) $display("FAIL lhu_stall_cycles got=%0d exp=2", r_stall); else n_pass++;
  endtask

  task automatic test_misaligned();
    run_op(OP_LD, 3'b010, 32'h0000_0006, 32'h0, 5'd2, 1'b1, 32'h0, 0);
    n_checks++; if (r_req !== 1'b0) $display("FAIL lw_mis_req got=%b exp=0", r_req); else n_pass++;
    n_checks++; if ({r_exc, r_wbv, r_wbwe} !== 3'b110) $display("FAIL lw_mis_exc got exc/v/we=%b exp=110", {r_exc, r_wbv, r_wbwe}); else n_pass++;
    n_checks++; if (r_stall != 0) $display("FAIL lw_mis_stall got=%0d exp=0", r_stall); else n_pass++;
    n_checks++; if (r_after !== 1'b0) $display("FAIL lw_mis_pulse got=%b exp=0", r_after); else n_pass++;
    run_op(OP_S, 3'b011, 32'h0000_0010, 32'h55, 5'd2, 1'b0, 32'h0, 0);
    n_checks++; if ({r_req, r_exc, r_wbv} !== 3'b011) $display("FAIL st_illegal got req/exc/v=%b exp=011", {r_req, r_exc, r_wbv}); else n_pass++;
  endtask

  task automatic test_back_to_back();
    i_valid = 1'b1; i_opcode = OP_S; i_func3 = 3'b010; i_result = 32'h20; i_data_store = 32'hCAFE_F00D;
    i_rd = 5'd1; i_reg_we = 1'b0;
    #1;
    n_checks++; if (o_stall !== 1'b1) $display("FAIL b2b_sw_stall got=%b exp=1", o_stall); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if ({o_mem_req, o_mem_we, o_mem_wstrb, o_mem_wdata} !== {1'b1, 1'b1, 4'b1111, 32'hCAFE_F00D})
      $display("FAIL b2b_sw_req got req=%b we=%b strb=%b wdata=%h", o_mem_req, o_mem_we, o_mem_wstrb, o_mem_wdata); else n_pass++;
    i_mem_ack = 1'b1;
    @(posedge clk); #1;
    i_mem_ack = 1'b0;
    i_opcode = OP_LD; i_func3 = 3'b010; i_result = 32'h24; i_rd = 5'd7; i_reg_we = 1'b1;
    n_checks++; if ({o_wb_valid, o_wb_we, o_mem_req} !== 3'b100)
      $display("FAIL b2b_sw_retire got v/we/req=%b exp=100", {o_wb_valid, o_wb_we, o_mem_req}); else n_pass++;
    #1;
    n_checks++; if (o_stall !== 1'b1) $display("FAIL b2b_lw_stall got=%b exp=1", o_stall); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if ({o_mem_req, o_mem_we, o_mem_addr} !== {1'b1, 1'b0, 32'h24})
      $display("FAIL b2b_lw_req got req=%b we=%b addr=%h", o_mem_req, o_mem_we, o_mem_addr); else n_pass++;
    i_valid = 1'b0; i_mem_ack = 1'b1; i_mem_rdata = 32'h8765_4321;
    @(posedge clk); #1;
    i_mem_ack = 1'b0;
    n_checks++; if ({o_wb_valid, o_wb_we, o_wb_rd, o_wb_data} !== {1'b1, 1'b1, 5'd7, 32'h8765_4321})
      $display("FAIL b2b_lw_retire got v=%b we=%b rd=%0d data=%h exp data=87654321", o_wb_valid, o_wb_we, o_wb_rd, o_wb_data);
    else n_pass++;
    n_checks++; if (o_stall !== 1'b0) $display("FAIL b2b_stall_fall got=%b exp=0", o_stall); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] a, d, rdata;
    logic [4:0]  rd;
    logic        rwe;
    int          aw;
    exp_t        e;
    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 3))
        0: op = OP_LD;
        1: op = OP_S;
        2: op = OP_R;
        default: op = 7'b0010011;
      endcase
      f3 = 3'($urandom); a = $urandom; d = $urandom; rdata = $urandom;
      rd = 5'($urandom); rwe = 1'($urandom); aw = $urandom_range(0, 3);
      e = model(op, f3, a, d, rwe, rdata);
      run_op(op, f3, a, d, rd, rwe, rdata, aw);
      n_checks++; if ({r_req, r_exc} !== {e.mem, e.exc})
        $display("FAIL rnd_kind op=%h f3=%0d a=%h got req/exc=%b exp=%b", op, f3, a, {r_req, r_exc}, {e.mem, e.exc}); else n_pass++;
      n_checks++; if ({r_wbv, r_wbrd, r_wbwe, r_after} !== {1'b1, rd, e.wb_we, 1'b0})
        $display("FAIL rnd_retire op=%h got v=%b rd=%0d we=%b again=%b exp rd=%0d we=%b", op, r_wbv, r_wbrd, r_wbwe, r_after, rd, e.wb_we);
      else n_pass++;
      n_checks++; if (r_stall != (e.mem ? aw + 2 : 0))
        $display("FAIL rnd_stall op=%h got=%0d exp=%0d", op, r_stall, e.mem ? aw + 2 : 0); else n_pass++;
      if (e.mem) begin
        n_checks++; if ({r_addr, r_we, r_wstrb, r_unstable != 0, r_spur != 0} !== {e.addr, e.we, e.wstrb, 1'b0, 1'b0})
          $display("FAIL rnd_req got addr=%h we=%b strb=%b unst=%0d exp addr=%h we=%b strb=%b", r_addr, r_we, r_wstrb, r_unstable, e.addr, e.we, e.wstrb);
        else n_pass++;
      end
      if (e.mem && e.we) begin
        n_checks++; if (r_wdata !== e.wdata) $display("FAIL rnd_wdata f3=%0d a=%h got=%h exp=%h", f3, a, r_wdata, e.wdata); else n_pass++;
      end
      if (!e.exc && !e.we) begin
        n_checks++; if (r_wbdata !== e.wb_data) $display("FAIL rnd_wbdata op=%h f3=%0d a=%h got=%h exp=%h", op, f3, a, r_wbdata, e.wb_data); else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_store();
    test_load();
    test_misaligned();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
